// File: rtl/condicionador_sensores_if.sv
// condicionador_sensores_if: sensor conditioning control/data bundle
interface condicionador_sensores_if;
    logic       tick;
    logic [5:0] sensores_in;
    logic       monitorar;
    logic       limpar_falha;
    logic [5:0] sensores_out;
    logic [5:0] subida;
    logic [5:0] descida;
    logic [5:0] falha;
    logic       alarme_sensor;

    modport master (
        output tick, sensores_in, monitorar, limpar_falha,
        input  sensores_out, subida, descida, falha, alarme_sensor
    );

    modport slave (
        input  tick, sensores_in, monitorar, limpar_falha,
        output sensores_out, subida, descida, falha, alarme_sensor
    );
endinterface

// File: rtl/condicionador_sensores.sv
// condicionador_sensores: sync, debounce, edge pulses and stuck detection for six line sensors
module condicionador_sensores #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int STUCK_TICKS    = 1000
) (
    input logic                     clock,
    input logic                     reset,
    condicionador_sensores_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int SW = $clog2(STUCK_TICKS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [SW-1:0] STK_LAST = SW'(STUCK_TICKS - 1);
    localparam logic [SW-1:0] STK_MAX  = SW'(STUCK_TICKS);

    logic [5:0] r_s1, r_s2;
    logic [5:0] w_filt, w_sub, w_des, w_falha;
    logic       r_alarme;

    // two-flop synchroniser on every raw sensor line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= bus.sensores_in;
            r_s2 <= r_s1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 6; g++) begin : g_ch
            logic [DW-1:0] r_deb;
            logic [SW-1:0] r_stk;
            logic          r_filt, r_sub, r_des, r_falha;
            logic          w_diff, w_acc, w_stk_clr;

            assign w_diff    = r_s2[g] != r_filt;
            assign w_acc     = w_diff && bus.tick && (r_deb == DEB_LAST);
            assign w_stk_clr = bus.limpar_falha || !bus.monitorar || w_acc;

            // debounce: count ticks while the synced level differs, accept on the last one
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_deb  <= '0;
                    r_filt <= 1'b0;
                    r_sub  <= 1'b0;
                    r_des  <= 1'b0;
                end else begin
                    r_deb  <= (!w_diff || w_acc) ? '0 : bus.tick ? r_deb + DW'(1) : r_deb;
                    r_filt <= w_acc ? r_s2[g] : r_filt;
                    r_sub  <= w_acc && r_s2[g];
                    r_des  <= w_acc && !r_s2[g];
                end
            end

            // saturating quiet-time counter; fault is sticky until cleared, clear beats set
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_stk   <= '0;
                    r_falha <= 1'b0;
                end else begin
                    r_stk   <= w_stk_clr ? '0 : (bus.tick && r_stk != STK_MAX) ? r_stk + SW'(1) : r_stk;
                    r_falha <= !bus.limpar_falha &&
                               (r_falha || (!w_stk_clr && bus.tick && r_stk == STK_LAST));
                end
            end

            assign w_filt[g]  = r_filt;
            assign w_sub[g]   = r_sub;
            assign w_des[g]   = r_des;
            assign w_falha[g] = r_falha;
        end
    endgenerate

    // summary alarm, one clock behind the per-channel faults
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_alarme <= 1'b0;
        else       r_alarme <= |w_falha;
    end

    assign bus.sensores_out  = w_filt;
    assign bus.subida        = w_sub;
    assign bus.descida       = w_des;
    assign bus.falha         = w_falha;
    assign bus.alarme_sensor = r_alarme;
endmodule

// File: tb/tb_condicionador_sensores.sv
// tb_condicionador_sensores: directed bench with a per-cycle behavioural model
module tb_condicionador_sensores;
    localparam int D = 4;
    localparam int S = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    condicionador_sensores_if bus();

    condicionador_sensores #(.DEBOUNCE_TICKS(D), .STUCK_TICKS(S)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    // model state: synced samples, accepted level, ticks a differing level has lasted,
    // ticks of quiet time while monitoring
    logic [5:0] m_s1 = '0, m_s2 = '0, m_filt = '0, m_sub = '0, m_des = '0, m_falha = '0;
    logic       m_alarm = 1'b0;
    int         m_run[6];
    int         m_quiet[6];
    logic       c_rst, c_tick, c_mon, c_clr, chg, prev_any;
    logic [5:0] c_in;

    initial begin : model
        for (int c = 0; c < 6; c++) begin
            m_run[c] = 0;
            m_quiet[c] = 0;
        end
        forever begin
            @(posedge clock);
            c_rst = reset; c_tick = bus.tick; c_in = bus.sensores_in;
            c_mon = bus.monitorar; c_clr = bus.limpar_falha;
            if (c_rst) begin
                m_s1 = '0; m_s2 = '0; m_filt = '0; m_sub = '0; m_des = '0; m_falha = '0; m_alarm = 1'b0;
                for (int c = 0; c < 6; c++) begin
                    m_run[c] = 0;
                    m_quiet[c] = 0;
                end
            end else begin
                prev_any = |m_falha;
                for (int c = 0; c < 6; c++) begin
                    chg = 1'b0;
                    if (m_s2[c] == m_filt[c]) m_run[c] = 0;
                    else if (c_tick) begin
                        m_run[c] = m_run[c] + 1;
                        if (m_run[c] == D) begin
                            chg = 1'b1;
                            m_filt[c] = m_s2[c];
                            m_run[c] = 0;
                        end
                    end
                    m_sub[c] = chg && m_filt[c];
                    m_des[c] = chg && !m_filt[c];
                    if (c_clr || !c_mon || chg) m_quiet[c] = 0;
                    else if (c_tick && m_quiet[c] < S) begin
                        m_quiet[c] = m_quiet[c] + 1;
                        if (m_quiet[c] == S) m_falha[c] = 1'b1;
                    end
                    if (c_clr) m_falha[c] = 1'b0;
                end
                m_s2 = m_s1;
                m_s1 = c_in;
                m_alarm = prev_any;
            end
            #1;
            chk("cyc_out", bus.sensores_out, m_filt);
            chk("cyc_subida", bus.subida, m_sub);
            chk("cyc_descida", bus.descida, m_des);
            chk("cyc_falha", bus.falha, m_falha);
            chk("cyc_alarme", {5'b0, bus.alarme_sensor}, {5'b0, m_alarm});
        end
    end

    initial begin : stim
        bus.tick = 1'b1;
        bus.sensores_in = '0;
        bus.monitorar = 1'b0;
        bus.limpar_falha = 1'b0;
        step(3);
        reset = 1'b0;
        step(4);
        chk("idle_out", bus.sensores_out, 6'h00);
        chk("idle_pulses", bus.subida | bus.descida, 6'h00);
        chk("idle_falha", bus.falha, 6'h00);
        chk("idle_alarme", {5'b0, bus.alarme_sensor}, 6'h00);

        bus.sensores_in = 6'h01;
        step(5);
        chk("pg_rise_e5", bus.sensores_out, 6'h00);
        step(1);
        chk("pg_rise_e6", bus.sensores_out, 6'h01);
        chk("pg_subida_e6", bus.subida, 6'h01);
        chk("pg_descida_e6", bus.descida, 6'h00);
        step(1);
        chk("pg_subida_e7", bus.subida, 6'h00);
        bus.sensores_in = 6'h00;
        step(5);
        chk("pg_fall_e5", bus.sensores_out, 6'h01);
        step(1);
        chk("pg_fall_e6", bus.sensores_out, 6'h00);
        chk("pg_descida_e6", bus.descida, 6'h01);
        step(1);
        chk("pg_descida_e7", bus.descida, 6'h00);

        bus.sensores_in = 6'h02;
        step(3);
        bus.sensores_in = 6'h00;
        step(8);
        chk("ch_glitch_out", bus.sensores_out, 6'h00);
        bus.sensores_in = 6'h02;
        for (int n = 1; n <= 10; n++) begin
            bus.tick = (n % 2 == 0);
            step(1);
            if (n == 9) chk("ch_slow_e9", bus.sensores_out, 6'h00);
        end
        chk("ch_slow_e10", bus.sensores_out, 6'h02);
        chk("ch_slow_subida", bus.subida, 6'h02);
        bus.tick = 1'b1;

        bus.sensores_in = 6'h00;
        reset = 1'b1;
        #1;
        chk("async_rst_out", bus.sensores_out, 6'h00);
        step(2);
        reset = 1'b0;
        bus.sensores_in = 6'h01;
        step(5);
        reset = 1'b1;
        #1;
        chk("rst_mid_deb", bus.sensores_out, 6'h00);
        step(1);
        reset = 1'b0;
        step(5);
        chk("rst_relat_e5", bus.sensores_out, 6'h00);
        step(1);
        chk("rst_relat_e6", bus.sensores_out, 6'h01);

        bus.sensores_in = 6'h00;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        bus.sensores_in = 6'h04;
        step(2);
        bus.monitorar = 1'b1;
        step(4);
        chk("ro_acc_e4", bus.sensores_out, 6'h04);
        step(3);
        chk("stk_e7", bus.falha, 6'h00);
        step(1);
        chk("stk_e8", bus.falha, 6'h3B);
        chk("alarme_e8", {5'b0, bus.alarme_sensor}, 6'h00);
        step(1);
        chk("alarme_e9", {5'b0, bus.alarme_sensor}, 6'h01);
        step(2);
        chk("ro_stk_e11", bus.falha, 6'h3B);
        step(1);
        chk("ro_stk_e12", bus.falha, 6'h3F);

        bus.limpar_falha = 1'b1;
        step(1);
        chk("clr_falha", bus.falha, 6'h00);
        chk("clr_alarme_lag", {5'b0, bus.alarme_sensor}, 6'h01);
        bus.limpar_falha = 1'b0;
        step(1);
        chk("clr_alarme", {5'b0, bus.alarme_sensor}, 6'h00);
        step(6);
        chk("clr_k7", bus.falha, 6'h00);
        bus.limpar_falha = 1'b1;
        step(1);
        chk("clr_wins_k8", bus.falha, 6'h00);
        bus.limpar_falha = 1'b0;
        step(7);
        chk("refault_k15", bus.falha, 6'h00);
        step(1);
        chk("refault_k16", bus.falha, 6'h3F);
        bus.monitorar = 1'b0;
        step(3);
        chk("sticky_falha", bus.falha, 6'h3F);
        chk("sticky_alarme", {5'b0, bus.alarme_sensor}, 6'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
